// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification and system reset release.
// Define PLL_LOCK_SUPERVISOR_IRQ_EN to add the one-cycle irq event output.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             clk_in1,
  input  logic             reset,
  input  logic             locked,
  input  logic             clear_cnt,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
`ifdef PLL_LOCK_SUPERVISOR_IRQ_EN
  output logic             irq,
`endif
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0]    RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0]    TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock counts as stable cycle one.
  localparam logic [CW-1:0]    STB_LAST = CW'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
  localparam logic [CW-1:0]    CYC_ONE  = CW'(1);
  localparam logic [CNT_W-1:0] EVT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] EVT_MAX  = '1;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       lock_loss_cnt_q, lock_loss_cnt_d;
  logic [CNT_W-1:0]       timeout_cnt_q, timeout_cnt_d;
  logic                   locked_s;
  logic                   loss_evt;
  logic                   tmo_evt;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], locked};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CYC_ONE;
    loss_evt = 1'b0;
    tmo_evt  = 1'b0;
    case (state_q)
      PLL_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          if (STABLE_CYCLES <= 1) begin
            state_d = RUN;
          end else begin
            state_d = STABLE;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = PLL_RESET;
          tmo_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          state_d  = PLL_RESET;
          loss_evt = 1'b1;
        end
      end
      default: begin
        state_d = PLL_RESET;
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    lock_loss_cnt_d = lock_loss_cnt_q;
    timeout_cnt_d   = timeout_cnt_q;
    if (loss_evt && (lock_loss_cnt_q != EVT_MAX)) begin
      lock_loss_cnt_d = lock_loss_cnt_q + EVT_ONE;
    end
    if (tmo_evt && (timeout_cnt_q != EVT_MAX)) begin
      timeout_cnt_d = timeout_cnt_q + EVT_ONE;
    end
    if (clear_cnt) begin
      lock_loss_cnt_d = '0;
      timeout_cnt_d   = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_comb begin
    pll_rst_d = (state_d == PLL_RESET);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      state_q         <= PLL_RESET;
      cnt_q           <= '0;
      sync_q          <= '0;
      pll_rst_q       <= 1'b1;
      sys_rst_q       <= 1'b1;
      ready_q         <= 1'b0;
      lock_loss_cnt_q <= '0;
      timeout_cnt_q   <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sync_q          <= sync_d;
      pll_rst_q       <= pll_rst_d;
      sys_rst_q       <= sys_rst_d;
      ready_q         <= ready_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
      timeout_cnt_q   <= timeout_cnt_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = lock_loss_cnt_q;
  assign timeout_cnt   = timeout_cnt_q;

`ifdef PLL_LOCK_SUPERVISOR_IRQ_EN
  logic irq_q, irq_d;

  // Pulses on every increment attempt, even when saturated or cleared.
  always_comb begin
    irq_d = loss_evt | tmo_evt;
  end

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed self-checking bench for pll_lock_supervisor.
// Irq checks are compiled in when PLL_LOCK_SUPERVISOR_IRQ_EN is defined.
module tb_pll_lock_supervisor;

  logic       clk_in1;
  logic       reset;
  logic       locked;
  logic       clear_cnt;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [3:0] lock_loss_cnt;
  logic [3:0] timeout_cnt;
`ifdef PLL_LOCK_SUPERVISOR_IRQ_EN
  logic       irq;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pll_lock_supervisor #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .CNT_W         (4)
  ) dut (
    .clk_in1      (clk_in1),
    .reset        (reset),
    .locked       (locked),
    .clear_cnt    (clear_cnt),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
`ifdef PLL_LOCK_SUPERVISOR_IRQ_EN
    .irq          (irq),
`endif
    .lock_loss_cnt(lock_loss_cnt),
    .timeout_cnt  (timeout_cnt)
  );

  initial begin
    clk_in1 = 1'b0;
    forever #5 clk_in1 = ~clk_in1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in1);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic pr, input logic sr, input logic rd);
    check_eq({tag, "_pll_rst"}, 32'(pll_rst), 32'(pr));
    check_eq({tag, "_sys_rst"}, 32'(sys_rst), 32'(sr));
    check_eq({tag, "_ready"},   32'(ready),   32'(rd));
  endtask

  task automatic check_irq(input string tag, input logic exp);
`ifdef PLL_LOCK_SUPERVISOR_IRQ_EN
    check_eq({tag, "_irq"}, 32'(irq), 32'(exp));
`else
    if (exp === 1'bx) $display("unused irq expectation %s", tag);
`endif
  endtask

  initial begin
    int sat;
    reset     = 1'b1;
    locked    = 1'b0;
    clear_cnt = 1'b0;

    // Reset state, then the first PLL reset pulse.
    step(3);
    check_outs("rst", 1'b1, 1'b1, 1'b0);
    check_eq("rst_loss", 32'(lock_loss_cnt), 32'd0);
    check_eq("rst_tmo",  32'(timeout_cnt),   32'd0);
    check_irq("rst", 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_outs($sformatf("t1_%0d", i), (i < 3), 1'b1, 1'b0);
    end

    // Lock arrives 10 cycles after pll_rst falls; release after 2+8 cycles.
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_outs($sformatf("t2_wait_%0d", i), 1'b0, 1'b1, 1'b0);
    end
    locked = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check_outs($sformatf("t2_lock_%0d", k), 1'b0, (k != 10), (k == 10));
    end
    check_eq("t2_loss", 32'(lock_loss_cnt), 32'd0);
    check_eq("t2_tmo",  32'(timeout_cnt),   32'd0);

    // One-cycle lock drop in RUN.
    locked = 1'b0;
    step(1);
    check_outs("t4_e0", 1'b0, 1'b0, 1'b1);
    locked = 1'b1;
    step(1);
    check_outs("t4_e1", 1'b0, 1'b0, 1'b1);
    step(1);
    check_outs("t4_e2", 1'b1, 1'b1, 1'b0);
    check_eq("t4_loss", 32'(lock_loss_cnt), 32'd1);
    check_irq("t4_e2", 1'b1);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check_outs($sformatf("t4_relock_%0d", k), (k <= 3), (k != 12), (k == 12));
      check_irq($sformatf("t4_relock_%0d", k), 1'b0);
    end
    check_eq("t4_loss_hold", 32'(lock_loss_cnt), 32'd1);

    // clear_cnt coincident with a lock-loss increment.
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(1);
    clear_cnt = 1'b1;
    step(1);
    clear_cnt = 1'b0;
    check_outs("t6a", 1'b1, 1'b1, 1'b0);
    check_eq("t6a_loss", 32'(lock_loss_cnt), 32'd0);
    check_irq("t6a", 1'b1);

    // Lock glitch during STABLE after 5 qualified high cycles.
    for (int k = 1; k <= 18; k++) begin
      if (k == 8) locked = 1'b0;
      if (k == 9) locked = 1'b1;
      step(1);
      check_outs($sformatf("t5_%0d", k), (k <= 3), (k != 18), (k == 18));
    end
    check_eq("t5_loss", 32'(lock_loss_cnt), 32'd0);
    check_eq("t5_tmo",  32'(timeout_cnt),   32'd0);

    // Loss of lock in RUN, then repeated timeouts with locked held low.
    locked = 1'b0;
    step(2);
    check_outs("t3_pre", 1'b0, 1'b0, 1'b1);
    step(1);
    check_outs("t3_loss", 1'b1, 1'b1, 1'b0);
    check_eq("t3_loss_cnt", 32'(lock_loss_cnt), 32'd1);
    for (int k = 1; k <= 36; k++) begin
      step(1);
      check_outs($sformatf("t3_first_%0d", k), (k <= 3) || (k == 36), 1'b1, 1'b0);
      check_eq($sformatf("t3_first_tmo_%0d", k), 32'(timeout_cnt), (k == 36) ? 32'd1 : 32'd0);
      check_irq($sformatf("t3_first_%0d", k), (k == 36));
    end
    for (int t = 2; t <= 20; t++) begin
      sat = (t - 1 > 15) ? 15 : t - 1;
      step(35);
      check_eq($sformatf("t3_pre_pll_%0d", t), 32'(pll_rst), 32'd0);
      check_eq($sformatf("t3_pre_tmo_%0d", t), 32'(timeout_cnt), 32'(sat));
      step(1);
      sat = (t > 15) ? 15 : t;
      check_eq($sformatf("t3_pll_%0d", t), 32'(pll_rst), 32'd1);
      check_eq($sformatf("t3_tmo_%0d", t), 32'(timeout_cnt), 32'(sat));
      check_irq($sformatf("t3_tmo_%0d", t), 1'b1);
    end
    check_eq("t3_sat", 32'(timeout_cnt), 32'd15);

    // Relock to RUN, then asynchronous reset between clock edges.
    locked = 1'b1;
    step(11);
    check_outs("t6b_pre", 1'b0, 1'b1, 1'b0);
    step(1);
    check_outs("t6b_run", 1'b0, 1'b0, 1'b1);
    check_eq("t6b_loss", 32'(lock_loss_cnt), 32'd1);
    check_eq("t6b_tmo",  32'(timeout_cnt),   32'd15);
    #2;
    reset = 1'b1;
    #1;
    check_outs("t6b_async", 1'b1, 1'b1, 1'b0);
    check_eq("t6b_async_loss", 32'(lock_loss_cnt), 32'd0);
    check_eq("t6b_async_tmo",  32'(timeout_cnt),   32'd0);
    step(2);
    check_outs("t6b_hold", 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_outs($sformatf("t6b_restart_%0d", i), (i < 3), 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
